// File: rtl/data_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter_pkg
// Purpose  : Operation encodings shared by the data RAM arbiter and its users.
// Revision : 1.0 - initial release
// ============================================================================
package data_ram_arbiter_pkg;

    localparam int DRA_OP_W = 2;

    localparam logic [DRA_OP_W-1:0] DRA_OP_READ  = 2'b00;
    localparam logic [DRA_OP_W-1:0] DRA_OP_WRITE = 2'b01;
    localparam logic [DRA_OP_W-1:0] DRA_OP_ADD   = 2'b10;
    localparam logic [DRA_OP_W-1:0] DRA_OP_RSVD  = 2'b11;

    // Every op except WRITE returns data (READ, ADD and the reserved code).
    function automatic logic dra_op_returns_data(input logic [DRA_OP_W-1:0] op);
        return (op != DRA_OP_WRITE);
    endfunction

    // Ops that store into the RAM.
    function automatic logic dra_op_writes_ram(input logic [DRA_OP_W-1:0] op);
        return (op == DRA_OP_WRITE) || (op == DRA_OP_ADD);
    endfunction

endpackage : data_ram_arbiter_pkg
`default_nettype wire

// File: rtl/dra_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : dra_wait_counter
// Purpose  : Saturating stall counter for the port-1 starvation guard.
//            Clear has priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
module dra_wait_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    // Count stalled cycles, stopping at MAX_WAIT until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == C_MAX);

endmodule : dra_wait_counter
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Purpose  : Shares the single-port data RAM between the CPU datapath (p0)
//            and the host/debug loader (p1). One accept per cycle, p0 has
//            priority. READ/ADD data is returned registered one cycle later;
//            ADD performs a read-modify-write in a single RAM cycle.
//            Optional macro DRA_STARVE_GUARD_EN forces a p1 grant after
//            MAX_WAIT stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int DADDR_WIDTH = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_WAIT    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   p0_valid,
    output logic                   p0_ready,
    input  logic [DRA_OP_W-1:0]    p0_op,
    input  logic [DADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]  p0_wdata,
    output logic                   p0_rvalid,
    output logic [DATA_WIDTH-1:0]  p0_rdata,

    input  logic                   p1_valid,
    output logic                   p1_ready,
    input  logic [DRA_OP_W-1:0]    p1_op,
    input  logic [DADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]  p1_wdata,
    output logic                   p1_rvalid,
    output logic [DATA_WIDTH-1:0]  p1_rdata,

    output logic [DADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]  ram_data_in,
    output logic                   ram_write,
    input  logic [DATA_WIDTH-1:0]  ram_data_out
);

    logic                   w_force1;
    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_any_grant;
    logic [DRA_OP_W-1:0]    w_sel_op;
    logic [DADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    logic [DADDR_WIDTH-1:0] r_last_addr;
    logic                   r_p0_rvalid;
    logic                   r_p1_rvalid;
    logic [DATA_WIDTH-1:0]  r_p0_rdata;
    logic [DATA_WIDTH-1:0]  r_p1_rdata;

`ifdef DRA_STARVE_GUARD_EN
    localparam int C_CNT_W = $clog2(MAX_WAIT + 1);

    logic [C_CNT_W-1:0] w_wait_count;
    logic               w_wait_at_max;

    // Stall = p1 asking but not granted; any p1 accept or withdrawal restarts.
    dra_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (C_CNT_W)
    ) u_wait_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (p1_valid & ~w_grant1),
        .clr    (w_grant1 | ~p1_valid),
        .count  (w_wait_count),
        .at_max (w_wait_at_max)
    );

    assign w_force1 = w_wait_at_max & p1_valid;
`else
    assign w_force1 = 1'b0;
`endif

    // Priority grant; nothing is granted while reset is held.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n) begin
            if (w_force1) begin
                w_grant1 = 1'b1;
            end else if (p0_valid) begin
                w_grant0 = 1'b1;
            end else if (p1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_any_grant = w_grant0 | w_grant1;
    assign p0_ready    = w_grant0;
    assign p1_ready    = w_grant1;

    // Route the winning request's fields to the RAM side.
    always_comb begin
        w_sel_op    = p0_op;
        w_sel_addr  = p0_addr;
        w_sel_wdata = p0_wdata;
        if (w_grant1) begin
            w_sel_op    = p1_op;
            w_sel_addr  = p1_addr;
            w_sel_wdata = p1_wdata;
        end
    end

    // ADD reads the old value combinationally and writes the sum back in the same cycle.
    assign ram_address = w_any_grant ? w_sel_addr : r_last_addr;
    assign ram_write   = w_any_grant & dra_op_writes_ram(w_sel_op);
    assign ram_data_in = (w_sel_op == DRA_OP_ADD) ? (ram_data_out + w_sel_wdata) : w_sel_wdata;

    // Capture read data for the granted port and remember the last granted address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_addr <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_grant0 & dra_op_returns_data(w_sel_op);
            r_p1_rvalid <= w_grant1 & dra_op_returns_data(w_sel_op);
            if (w_grant0 && dra_op_returns_data(w_sel_op)) begin
                r_p0_rdata <= ram_data_out;
            end
            if (w_grant1 && dra_op_returns_data(w_sel_op)) begin
                r_p1_rdata <= ram_data_out;
            end
            if (w_any_grant) begin
                r_last_addr <= w_sel_addr;
            end
        end
    end

    // A pending response is suppressed as soon as reset is asserted.
    assign p0_rvalid = r_p0_rvalid & rst_n;
    assign p1_rvalid = r_p1_rvalid & rst_n;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule : data_ram_arbiter
`default_nettype wire
